instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetches 32-bit RV32 instructions from the byte-wide code memory and hands them to decode.
//   Owns the fetch PC and issues four byte reads per instruction, MSB first.
//   Packs the bytes into one word, then presents word + PC on a valid/ready interface.
//   Sits between codemem (upstream) and the decode stage (downstream).
// PARAMETERS
//   ADDR_W    8     byte-address width of code memory (wraps mod 2**ADDR_W)
//   RESET_PC  0     fetch PC after reset; low 2 bits must be 0
// PORTS
//   clk            in   1       system clock, all logic on posedge
//   rst            in   1       synchronous, active-high reset
//   cs_code_mem    out  1       read request to codemem, one-cycle pulse per byte
//   pc             out  ADDR_W  byte address to codemem, held stable until the byte is captured
//   rdy_code_mem   in   1       codemem ready; goes low (busy), then high with data
//   pc_data        in   8       codemem read byte, valid while rdy_code_mem high after busy
//   redirect_valid in   1       branch/jump redirect strobe
//   redirect_pc    in   ADDR_W  redirect target; bits [1:0] ignored (forced 0)
//   instr          out  32      assembled instruction
//   instr_pc       out  ADDR_W  byte address of instr
//   instr_valid    out  1       instr/instr_pc valid
//   instr_ready    in   1       decode accepts when instr_valid & instr_ready
//   fetch_busy     out  1       high in every state except HOLD
// BEHAVIOUR
//   Reset:
//     - cs_code_mem=0, pc=0, instr=0, instr_pc=0, instr_valid=0, fetch_busy=1
//     - fetch_pc=RESET_PC, byte_idx=0, state=REQ
//   FSM, states REQ, WAIT_LO, WAIT_HI, HOLD, DRAIN; all outputs registered.
//   REQ:
//     - cs_code_mem=1 for exactly this cycle; pc=fetch_pc+byte_idx
//     - go to WAIT_LO
//   WAIT_LO:
//     - wait for rdy_code_mem==0 (busy seen); then go to WAIT_HI
//   WAIT_HI:
//     - on rdy_code_mem==1, capture pc_data into lane 3-byte_idx
//       (idx0->[31:24], idx1->[23:16], idx2->[15:8], idx3->[7:0])
//     - idx<3: byte_idx++ and go to REQ
//     - idx==3: instr_valid=1, instr_pc=fetch_pc, go to HOLD
//   HOLD:
//     - instr, instr_pc and instr_valid held stable until instr_ready=1
//     - on accept: fetch_pc+=4 (mod 2**ADDR_W, 0xFC->0x00), byte_idx=0, go to REQ
//   Latency:
//     - a memory with 1 busy cycle takes 3 cycles per byte
//     - first instr_valid is 12 cycles after rst deasserts
//   Redirect (any state):
//     - fetch_pc=redirect_pc&~3, byte_idx=0, any partial word is discarded
//     - REQ or HOLD: go to REQ next cycle; instr_valid drops next cycle
//     - HOLD with instr_ready in the same cycle: the transfer counts, next fetch is the redirect target
//     - WAIT_LO/WAIT_HI: go to DRAIN, which finishes the outstanding memory transaction (busy then ready)
//       without capturing, then goes to REQ
//     - redirect during DRAIN: update the target only, stay in DRAIN
//   Only one memory request is outstanding at a time; cs_code_mem never pulses outside REQ.
//   rst mid-transaction: return to reset values immediately, no drain.
// CONFIGURATION
//   IFU_STALL_CNT_EN defined:
//     - adds output stall_cnt[15:0], reset 0
//     - increments each cycle in HOLD with instr_ready=0, or in WAIT_LO/WAIT_HI
//     - saturates at 0xFFFF
//   IFU_STALL_CNT_EN undefined: port and counter absent; no other behaviour change.
// STRUCTURE
//   ifu_pkg:
//     - state enum
//     - INSTR_BYTES=4
//     - LANE_MSB/LANE_LSB constants for byte-lane mapping
//   One sub-module, instr_byte_assembler: byte_idx counter, lane select, 32-bit word register, clear on redirect.
//   FSM, PC and handshake logic stay in instr_fetch_unit.
// TESTING
//   Memory model: 1-cycle busy, then ready; preload 40 10 00 B3 40 10 01 33 at addresses 0-7.
//   1. Reset, instr_ready=1
//      -> instr=0x401000B3 @instr_pc=0x00, then 0x40100133 @0x04
//      -> exactly 4 cs_code_mem pulses per word, at addrs 0,1,2,3 then 4..7
//   2. instr_ready=0 for 10 cycles in HOLD
//      -> instr/instr_pc stable, no cs_code_mem pulse
//      -> release -> next request at pc=0x04
//   3. redirect_valid, redirect_pc=0x07, while in WAIT_HI of byte 2
//      -> DRAIN completes that read, nothing captured
//      -> next cs_code_mem at pc=0x04, word delivered with instr_pc=0x04
//   4. redirect to 0xFC; accept that word
//      -> next fetch_pc wraps, first request pc=0x00
//   5. rst asserted in WAIT_LO
//      -> next cycle all outputs at reset values, request at RESET_PC
//   6. IFU_STALL_CNT_EN: hold instr_ready=0 for 5 HOLD cycles
//      -> stall_cnt rises by 5 plus 2 per byte of memory wait

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [2:0] {
    REQ,
    WAIT_LO,
    WAIT_HI,
    HOLD,
    DRAIN
  } ifu_state_t;

  localparam int INSTR_BYTES = 4;

  // Byte index 0 is the most significant byte of the instruction word.
  localparam int LANE_MSB [INSTR_BYTES] = '{31, 23, 15, 7};
  localparam int LANE_LSB [INSTR_BYTES] = '{24, 16, 8, 0};

endpackage

// File: rtl/instr_byte_assembler.sv
// Packs four code-memory bytes (MSB first) into one 32-bit instruction word.
module instr_byte_assembler
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        capture,
  input  logic [7:0]  data,
  output logic [1:0]  byte_idx,
  output logic        last,
  output logic [31:0] word_full
);

  logic [31:0] word_q;

  assign last = (byte_idx == 2'(INSTR_BYTES - 1));

  // word_full already contains the byte being captured this cycle.
  for (genvar g = 0; g < INSTR_BYTES; g++) begin : g_lane
    assign word_full[LANE_MSB[g]:LANE_LSB[g]] =
      (byte_idx == 2'(g)) ? data : word_q[LANE_MSB[g]:LANE_LSB[g]];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (capture) begin
      byte_idx <= byte_idx + 2'd1;
      word_q   <= word_full;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Byte-wide instruction fetch with valid/ready hand-off to decode.
// Optional IFU_STALL_CNT_EN adds a saturating stall_cnt output.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   REQ     | issue one byte read at fetch_pc + byte_idx
//   WAIT_LO | wait for codemem to go busy
//   WAIT_HI | wait for codemem ready, capture the byte
//   HOLD    | full word presented, wait for decode to accept
//   DRAIN   | finish a read abandoned by a redirect, discard data
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              cs_code_mem,
  output logic [ADDR_W-1:0] pc,
  input  logic              rdy_code_mem,
  input  logic [7:0]        pc_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
`ifdef IFU_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              fetch_busy
);

  ifu_state_t        state, next_state;
  logic [ADDR_W-1:0] fetch_pc;
  logic              drain_seen;
  logic [1:0]        byte_idx;
  logic              last;
  logic [31:0]       word_full;
  logic              capture;
  logic              unused_redirect_lsb;

  logic              cs_d, instr_valid_d, fetch_busy_d;
  logic [ADDR_W-1:0] pc_d, instr_pc_d;
  logic [31:0]       instr_d;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign capture = (state == WAIT_HI) && rdy_code_mem && !redirect_valid;

  instr_byte_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (redirect_valid),
    .capture  (capture),
    .data     (pc_data),
    .byte_idx (byte_idx),
    .last     (last),
    .word_full(word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      REQ:     next_state = redirect_valid ? REQ : WAIT_LO;
      WAIT_LO: if (redirect_valid)    next_state = DRAIN;
               else if (!rdy_code_mem) next_state = WAIT_HI;
      WAIT_HI: if (redirect_valid)    next_state = DRAIN;
               else if (rdy_code_mem)  next_state = last ? HOLD : REQ;
      HOLD:    if (redirect_valid || instr_ready) next_state = REQ;
      DRAIN:   if (drain_seen && rdy_code_mem)    next_state = REQ;
      default: next_state = REQ;
    endcase
  end

  always_comb begin
    cs_d          = (state == REQ) && !redirect_valid;
    pc_d          = cs_d ? fetch_pc + ADDR_W'(byte_idx) : pc;
    instr_d       = (capture && last) ? word_full : instr;
    instr_pc_d    = (capture && last) ? fetch_pc  : instr_pc;
    instr_valid_d = (next_state == HOLD);
    fetch_busy_d  = (next_state != HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_code_mem <= 1'b0;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_busy  <= 1'b1;
    end else begin
      cs_code_mem <= cs_d;
      pc          <= pc_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= instr_valid_d;
      fetch_busy  <= fetch_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      fetch_pc <= RESET_PC;
    else if (redirect_valid)
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (state == HOLD && instr_ready)
      fetch_pc <= fetch_pc + ADDR_W'(INSTR_BYTES);
  end

  // Remembers whether the abandoned read has already gone busy before DRAIN.
  always_ff @(posedge clk) begin
    if (rst)
      drain_seen <= 1'b0;
    else if (state != DRAIN)
      drain_seen <= (state == WAIT_HI) || (state == WAIT_LO && !rdy_code_mem);
    else if (!rdy_code_mem)
      drain_seen <= 1'b1;
  end

`ifdef IFU_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (((state == HOLD && !instr_ready) || state == WAIT_LO || state == WAIT_HI)
             && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a 1-cycle-busy code memory model.
module tb_instr_fetch_unit;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cs_code_mem;
  logic [ADDR_W-1:0] pc;
  logic              rdy_code_mem;
  logic [7:0]        pc_data;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic              fetch_busy;
`ifdef IFU_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  logic [7:0] cs_q [$];

  always #5 clk = ~clk;

  // Code memory: busy during the request cycle, ready with data the cycle after.
  assign rdy_code_mem = ~cs_code_mem;
  assign pc_data      = mem[pc];

  always @(negedge clk) if (cs_code_mem) cs_q.push_back(pc);

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .cs_code_mem   (cs_code_mem),
    .pc            (pc),
    .rdy_code_mem  (rdy_code_mem),
    .pc_data       (pc_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
`ifdef IFU_STALL_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .fetch_busy    (fetch_busy)
  );

  typedef struct {
    logic [7:0]  redir;
    logic        ready_same;
    logic [7:0]  exp_pc;
    logic [31:0] exp_instr;
    logic [7:0]  exp_next_req;
  } vec_t;

  vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    cs_q.delete();
  endtask

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    while (!instr_valid && cyc < 100) begin
      step();
      cyc++;
    end
    if (!instr_valid) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_cs(input int base, input string name);
    int n = 0;
    while (cs_q.size() <= base && n < 100) begin
      step();
      n++;
    end
    if (cs_q.size() <= base) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_req(input logic [7:0] addr, input string name);
    int n = 0;
    while (!(cs_code_mem && pc == addr) && n < 100) begin
      step();
      n++;
    end
    if (!(cs_code_mem && pc == addr)) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  function automatic logic [7:0] cs_at(input int i);
    return (i < cs_q.size()) ? cs_q[i] : 8'hxx;
  endfunction

  function automatic logic [31:0] word_at(input logic [7:0] p);
    return {mem[p], mem[p + 8'd1], mem[p + 8'd2], mem[p + 8'd3]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    64'(cs_code_mem), 64'd0);
    check({tag, "_pc"},    64'(pc),          64'd0);
    check({tag, "_instr"}, 64'(instr),       64'd0);
    check({tag, "_ipc"},   64'(instr_pc),    64'd0);
    check({tag, "_valid"}, 64'(instr_valid), 64'd0);
    check({tag, "_busy"},  64'(fetch_busy),  64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, base, base2, accepts;
    logic [7:0]  exp_pc, r_rpc, prev_pc;
    logic [31:0] prev_instr;
    logic        r_ready, r_redir, hold_chk;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h40; mem[1] = 8'h10; mem[2] = 8'h00; mem[3] = 8'hB3;
    mem[4] = 8'h40; mem[5] = 8'h10; mem[6] = 8'h01; mem[7] = 8'h33;
    mem[8'hFC] = 8'h12; mem[8'hFD] = 8'h34; mem[8'hFE] = 8'h56; mem[8'hFF] = 8'h78;

    vecs[0] = '{redir: 8'h07, ready_same: 1'b0, exp_pc: 8'h04, exp_instr: 32'h40100133, exp_next_req: 8'h08};
    vecs[1] = '{redir: 8'hFE, ready_same: 1'b1, exp_pc: 8'hFC, exp_instr: 32'h12345678, exp_next_req: 8'h00};
    vecs[2] = '{redir: 8'h01, ready_same: 1'b0, exp_pc: 8'h00, exp_instr: 32'h401000B3, exp_next_req: 8'h04};
    vecs[3] = '{redir: 8'h04, ready_same: 1'b1, exp_pc: 8'h04, exp_instr: 32'h40100133, exp_next_req: 8'h08};

    // Reset values, first-word latency, two sequential words.
    instr_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    check_reset_outputs("t1_rst");
    rst = 1'b0;
    cs_q.delete();
    wait_valid("t1_first", cyc);
    check("t1_latency", 64'(cyc), 64'd12);
    check("t1_w0_instr", 64'(instr), 64'h401000B3);
    check("t1_w0_pc", 64'(instr_pc), 64'h00);
    step();
    wait_valid("t1_second", cyc);
    check("t1_w1_instr", 64'(instr), 64'h40100133);
    check("t1_w1_pc", 64'(instr_pc), 64'h04);
    instr_ready = 1'b0;
    check("t1_cs_count", 64'(cs_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) check("t1_cs_addr", 64'(cs_at(i)), 64'(i));

    // Back-pressure in HOLD.
    instr_ready = 1'b0;
    do_reset();
    wait_valid("t2_valid", cyc);
    base = cs_q.size();
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_hold", {instr_valid, fetch_busy, instr, instr_pc}, {1'b1, 1'b0, 32'h401000B3, 8'h00});
    end
    check("t2_no_cs", 64'(cs_q.size()), 64'(base));
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    wait_cs(base, "t2_next");
    check("t2_next_pc", 64'(cs_at(base)), 64'h04);
    wait_valid("t2_w1", cyc);

    // Redirect while waiting for byte 2 of the first word.
    instr_ready = 1'b1;
    do_reset();
    wait_req(8'h02, "t3_req2");
    step();
    redirect_valid = 1'b1;
    redirect_pc = 8'h07;
    base = cs_q.size();
    step();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    wait_cs(base, "t3_next");
    check("t3_next_pc", 64'(cs_at(base)), 64'h04);
    wait_valid("t3_valid", cyc);
    check("t3_instr", 64'(instr), 64'h40100133);
    check("t3_ipc", 64'(instr_pc), 64'h04);
    check("t3_cs_count", 64'(cs_q.size() - base), 64'd4);

    // Redirect table applied from HOLD.
    for (int v = 0; v < 4; v++) begin
      base = cs_q.size();
      redirect_valid = 1'b1;
      redirect_pc = vecs[v].redir;
      instr_ready = vecs[v].ready_same;
      step();
      redirect_valid = 1'b0;
      instr_ready = 1'b0;
      check("vec_drop", 64'(instr_valid), 64'd0);
      wait_valid("vec_valid", cyc);
      check("vec_ipc", 64'(instr_pc), 64'(vecs[v].exp_pc));
      check("vec_instr", 64'(instr), 64'(vecs[v].exp_instr));
      check("vec_first_req", 64'(cs_at(base)), 64'(vecs[v].exp_pc));
      base2 = cs_q.size();
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      wait_cs(base2, "vec_next");
      check("vec_next_req", 64'(cs_at(base2)), 64'(vecs[v].exp_next_req));
      wait_valid("vec_refill", cyc);
    end

    // Reset during WAIT_LO with a word already delivered.
    instr_ready = 1'b1;
    do_reset();
    wait_req(8'h05, "t5_req5");
    rst = 1'b1;
    step();
    check_reset_outputs("t5_rst");
    rst = 1'b0;
    instr_ready = 1'b0;
    base = cs_q.size();
    wait_cs(base, "t5_next");
    check("t5_req_pc", 64'(cs_at(base)), 64'h00);
    wait_valid("t5_valid", cyc);
    check("t5_instr", 64'(instr), 64'h401000B3);

`ifdef IFU_STALL_CNT_EN
    instr_ready = 1'b0;
    do_reset();
    check("t6_stall_rst", 64'(stall_cnt), 64'd0);
    wait_valid("t6_valid", cyc);
    check("t6_stall_fetch", 64'(stall_cnt), 64'd8);
    for (int i = 0; i < 5; i++) step();
    check("t6_stall_hold", 64'(stall_cnt), 64'd13);
`endif

    // Randomised traffic checked against a word-level model of the fetch stream.
    instr_ready = 1'b0;
    do_reset();
    exp_pc = 8'h00;
    accepts = 0;
    for (int c = 0; c < 3000; c++) begin
      r_ready = ($urandom_range(0, 2) != 0);
      r_redir = ($urandom_range(0, 24) == 0);
      r_rpc   = 8'($urandom);
      instr_ready = r_ready;
      redirect_valid = r_redir;
      redirect_pc = r_rpc;
      hold_chk = instr_valid && !r_ready && !r_redir;
      if (instr_valid && r_ready) begin
        check("rnd_ipc", 64'(instr_pc), 64'(exp_pc));
        check("rnd_instr", 64'(instr), 64'(word_at(exp_pc)));
        exp_pc = exp_pc + 8'd4;
        accepts++;
      end
      if (r_redir) exp_pc = r_rpc & 8'hFC;
      prev_instr = instr;
      prev_pc = instr_pc;
      step();
      if (hold_chk)
        check("rnd_hold", {instr_valid, instr, instr_pc}, {1'b1, prev_instr, prev_pc});
    end
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    check("rnd_accepts", 64'(accepts > 20), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
